regfile_arbiter: RTL and testbench

Shares the core's single register-file port set (two read ports, one write port) between two requesters: requester A, the core sequencer, and requester B, the debug/loader host. Each requester issues read/write commands over a valid/ready handshake. The arbiter grants one command per cycle using round-robin, with an optional lock for atomic multi-command sequences. It pipelines each command into a registered stage that drives the register file, then returns read data and a completion strobe to the issuing requester. It sits between the control FSM / debug port and `reg_file`.

---
 rtl/regfile_arbiter_pkg.sv | 30 +++
 rtl/regfile_arbiter_rr_arbiter2.sv | 27 ++
 rtl/regfile_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the register-file arbiter: lock states,
// requester IDs, default widths and the lock-state grant mask.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } lock_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int LOCK_MAX_DEF = 16;

    // Bit 0 allows requester A, bit 1 allows requester B.
    function automatic logic [1:0] lock_mask(input lock_state_e st);
        logic [1:0] m;
        case (st)
            FREE:    m = 2'b11;
            LOCK_A:  m = 2'b01;
            LOCK_B:  m = 2'b10;
            default: m = 2'b11;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: masked requests, tie goes to the requester
// that was not granted last. Grant is one-hot or zero.
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    logic [1:0] elig_s;

    assign elig_s = req_i & mask_i;

    // One-hot grant selection
    always_comb begin
        gnt_o = 2'b00;
        case (elig_s)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == REQ_B) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register-file port set between two requesters with round-robin
// arbitration, an atomic lock with idle timeout, and a two-stage pipeline.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_lock,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_raddr1,
    input  logic [ADDR_W-1:0] a_raddr2,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rdata1,
    output logic [DATA_W-1:0] a_rdata2,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_lock,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_raddr1,
    input  logic [ADDR_W-1:0] b_raddr2,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rdata1,
    output logic [DATA_W-1:0] b_rdata2,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              lock_timeout
);

    // The counter only needs to hold LOCK_MAX-1; the LOCK_MAX-th idle cycle fires the timeout.
    localparam int               CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        gnt_s;
    logic [1:0]        mask_s;
    logic              accept_s;
    logic              win_s;
    logic              lock_owner_s;
    logic              timeout_s;
    logic              win_lock_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_raddr1_s;
    logic [ADDR_W-1:0] win_raddr2_s;
    logic [ADDR_W-1:0] win_waddr_s;
    logic [DATA_W-1:0] win_wdata_s;

    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    logic              stg_vld_q, stg_id_q, stg_we_q;
    logic [ADDR_W-1:0] stg_raddr1_q, stg_raddr2_q, stg_waddr_q;
    logic [DATA_W-1:0] stg_wdata_q;

    logic              a_rsp_q, b_rsp_q;
    logic [DATA_W-1:0] a_rdata1_q, a_rdata2_q, b_rdata1_q, b_rdata2_q;

    assign mask_s = lock_mask(state_q);

    rr_arbiter2 u_arb (
        .req_i  ({b_valid, a_valid}),
        .mask_i (mask_s),
        .last_i (last_q),
        .gnt_o  (gnt_s)
    );

    assign a_ready  = gnt_s[0];
    assign b_ready  = gnt_s[1];
    assign accept_s = |gnt_s;
    assign win_s    = gnt_s[1];

    // Select the granted requester's command fields
    always_comb begin
        if (win_s == REQ_B) begin
            win_lock_s   = b_lock;
            win_we_s     = b_we;
            win_raddr1_s = b_raddr1;
            win_raddr2_s = b_raddr2;
            win_waddr_s  = b_waddr;
            win_wdata_s  = b_wdata;
        end else begin
            win_lock_s   = a_lock;
            win_we_s     = a_we;
            win_raddr1_s = a_raddr1;
            win_raddr2_s = a_raddr2;
            win_waddr_s  = a_waddr;
            win_wdata_s  = a_wdata;
        end
    end

    // Lock FSM state, idle counter and last-grant pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
            cnt_q   <= '0;
            last_q  <= REQ_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Lock FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            FREE: begin
                cnt_d = '0;
                if (accept_s) begin
                    last_d = win_s;
                    if (win_lock_s) begin
                        state_d = (win_s == REQ_B) ? LOCK_B : LOCK_A;
                    end else begin
                        state_d = FREE;
                    end
                end else begin
                    state_d = FREE;
                end
            end
            LOCK_A, LOCK_B: begin
                if (accept_s) begin
                    last_d  = win_s;
                    cnt_d   = '0;
                    state_d = win_lock_s ? state_q : FREE;
                end else if (timeout_s) begin
                    last_d  = lock_owner_s;
                    cnt_d   = '0;
                    state_d = FREE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = FREE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lock FSM outputs: current owner and revocation strobe
    always_comb begin
        lock_owner_s = (state_q == LOCK_B) ? REQ_B : REQ_A;
        if ((state_q != FREE) && !accept_s && (cnt_q == CNT_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    assign lock_timeout = timeout_s;

    // Stage register driving the register file; cleared when nothing is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld_q    <= 1'b0;
            stg_id_q     <= REQ_A;
            stg_we_q     <= 1'b0;
            stg_raddr1_q <= '0;
            stg_raddr2_q <= '0;
            stg_waddr_q  <= '0;
            stg_wdata_q  <= '0;
        end else if (accept_s) begin
            stg_vld_q    <= 1'b1;
            stg_id_q     <= win_s;
            stg_we_q     <= win_we_s;
            stg_raddr1_q <= win_raddr1_s;
            stg_raddr2_q <= win_raddr2_s;
            stg_waddr_q  <= win_waddr_s;
            stg_wdata_q  <= win_wdata_s;
        end else begin
            stg_vld_q    <= 1'b0;
            stg_id_q     <= REQ_A;
            stg_we_q     <= 1'b0;
            stg_raddr1_q <= '0;
            stg_raddr2_q <= '0;
            stg_waddr_q  <= '0;
            stg_wdata_q  <= '0;
        end
    end

    assign rf_raddr1 = stg_raddr1_q;
    assign rf_raddr2 = stg_raddr2_q;
    assign rf_waddr  = stg_waddr_q;
    assign rf_wdata  = stg_wdata_q;
    assign rf_we     = stg_we_q;

    // Per-requester response strobe and held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rsp_q    <= 1'b0;
            b_rsp_q    <= 1'b0;
            a_rdata1_q <= '0;
            a_rdata2_q <= '0;
            b_rdata1_q <= '0;
            b_rdata2_q <= '0;
        end else begin
            a_rsp_q <= stg_vld_q && (stg_id_q == REQ_A);
            b_rsp_q <= stg_vld_q && (stg_id_q == REQ_B);
            if (stg_vld_q && (stg_id_q == REQ_A)) begin
                a_rdata1_q <= rf_rdata1;
                a_rdata2_q <= rf_rdata2;
            end
            if (stg_vld_q && (stg_id_q == REQ_B)) begin
                b_rdata1_q <= rf_rdata1;
                b_rdata2_q <= rf_rdata2;
            end
        end
    end

    assign a_rsp_valid = a_rsp_q;
    assign b_rsp_valid = b_rsp_q;
    assign a_rdata1    = a_rdata1_q;
    assign a_rdata2    = a_rdata2_q;
    assign b_rdata1    = b_rdata1_q;
    assign b_rdata2    = b_rdata2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed vectors with literal expectations plus a
// per-cycle behavioural model of arbitration, locking, pipeline and responses.
module tb_regfile_arbiter;

    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic       valid;
        logic       lock;
        logic       we;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [2:0] wa;
        logic [7:0] wd;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_ready, a_lock, a_we, a_rsp_valid;
    logic [2:0] a_raddr1, a_raddr2, a_waddr;
    logic [7:0] a_wdata, a_rdata1, a_rdata2;
    logic       b_valid, b_ready, b_lock, b_we, b_rsp_valid;
    logic [2:0] b_raddr1, b_raddr2, b_waddr;
    logic [7:0] b_wdata, b_rdata1, b_rdata2;
    logic [2:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [7:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic       rf_we, lock_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.DATA_W(8), .ADDR_W(3), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_lock(a_lock), .a_we(a_we),
        .a_raddr1(a_raddr1), .a_raddr2(a_raddr2), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rdata1(a_rdata1), .a_rdata2(a_rdata2),
        .b_valid(b_valid), .b_ready(b_ready), .b_lock(b_lock), .b_we(b_we),
        .b_raddr1(b_raddr1), .b_raddr2(b_raddr2), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rdata1(b_rdata1), .b_rdata2(b_rdata2),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_we(rf_we),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .lock_timeout(lock_timeout)
    );

    // Simple register file attached to the rf_* port set
    logic [7:0] bregs [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    assign rf_rdata1 = bregs[rf_raddr1];
    assign rf_rdata2 = bregs[rf_raddr2];
    always @(posedge clk) begin
        if (rf_we) bregs[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_owner;   // -1 nobody, 0 A, 1 B
    int         m_last;
    int         m_idle;
    int         win;
    bit         ea, eb, to_exp;
    bit         st_v;
    int         st_id;
    logic       st_we;
    logic [2:0] st_ra1, st_ra2, st_wa;
    logic [7:0] st_wd;
    bit         rv_a, rv_b;
    logic [7:0] rda1, rda2, rdb1, rdb2;
    logic [7:0] mregs [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    cmd_t       wc;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs_a", {a_ready, a_rsp_valid, a_rdata1, a_rdata2, lock_timeout}, 64'd0);
            chk("rst_outs_b", {b_ready, b_rsp_valid, b_rdata1, b_rdata2}, 64'd0);
            chk("rst_outs_rf", {rf_we, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata}, 64'd0);
            m_owner = -1; m_last = 1; m_idle = 0;
            st_v = 0; st_id = 0; st_we = 0; st_ra1 = 0; st_ra2 = 0; st_wa = 0; st_wd = 0;
            rv_a = 0; rv_b = 0; rda1 = 0; rda2 = 0; rdb1 = 0; rdb2 = 0;
        end else begin
            ea = a_valid && (m_owner != 1);
            eb = b_valid && (m_owner != 0);
            if (ea && eb)  win = (m_last == 0) ? 1 : 0;
            else if (ea)   win = 0;
            else if (eb)   win = 1;
            else           win = -1;
            to_exp = (m_owner >= 0) && (win < 0) && (m_idle + 1 == LOCK_MAX);

            chk("m_a_ready", a_ready, win == 0);
            chk("m_b_ready", b_ready, win == 1);
            chk("m_rf_we", rf_we, st_v && st_we);
            chk("m_rf_addr", {rf_raddr1, rf_raddr2, rf_waddr}, {st_ra1, st_ra2, st_wa});
            chk("m_rf_wdata", rf_wdata, st_wd);
            chk("m_a_rsp", {a_rsp_valid, a_rdata1, a_rdata2}, {rv_a, rda1, rda2});
            chk("m_b_rsp", {b_rsp_valid, b_rdata1, b_rdata2}, {rv_b, rdb1, rdb2});
            chk("m_lock_timeout", lock_timeout, to_exp);

            // responses read the file as it stands before this stage's write lands
            rv_a = st_v && (st_id == 0);
            rv_b = st_v && (st_id == 1);
            if (rv_a) begin rda1 = mregs[st_ra1]; rda2 = mregs[st_ra2]; end
            if (rv_b) begin rdb1 = mregs[st_ra1]; rdb2 = mregs[st_ra2]; end
            if (st_v && st_we) mregs[st_wa] = st_wd;

            if (win == 0) wc = {a_valid, a_lock, a_we, a_raddr1, a_raddr2, a_waddr, a_wdata};
            else if (win == 1) wc = {b_valid, b_lock, b_we, b_raddr1, b_raddr2, b_waddr, b_wdata};
            else wc = '0;
            st_v = (win >= 0); st_id = (win == 1) ? 1 : 0;
            st_we = wc.we; st_ra1 = wc.ra1; st_ra2 = wc.ra2; st_wa = wc.wa; st_wd = wc.wd;

            if (win >= 0) begin
                m_last = win;
                m_idle = 0;
                m_owner = wc.lock ? win : -1;
            end else if (m_owner >= 0) begin
                if (to_exp) begin
                    m_last = m_owner; m_owner = -1; m_idle = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input cmd_t ca, input cmd_t cb);
        a_valid = ca.valid; a_lock = ca.lock; a_we = ca.we;
        a_raddr1 = ca.ra1; a_raddr2 = ca.ra2; a_waddr = ca.wa; a_wdata = ca.wd;
        b_valid = cb.valid; b_lock = cb.lock; b_we = cb.we;
        b_raddr1 = cb.ra1; b_raddr2 = cb.ra2; b_waddr = cb.wa; b_wdata = cb.wd;
    endtask

    task automatic step(input cmd_t ca, input cmd_t cb);
        @(posedge clk); #1;
        set_in(ca, cb);
        @(negedge clk);
    endtask

    function automatic cmd_t mk(input logic lk, input logic we, input logic [2:0] r1,
                                input logic [2:0] r2, input logic [2:0] wa, input logic [7:0] wd);
        cmd_t c;
        c.valid = 1'b1; c.lock = lk; c.we = we; c.ra1 = r1; c.ra2 = r2; c.wa = wa; c.wd = wd;
        return c;
    endfunction

    cmd_t idle_c = '0;
    cmd_t ca_c, cb_c;

    initial begin
        rst_n = 1'b0;
        set_in(idle_c, idle_c);
        @(negedge clk);
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_ready", {a_ready, b_ready}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single write from A: ready at T, rf at T+1, response at T+2
        step(mk(1'b0, 1'b1, 3'd3, 3'd0, 3'd3, 8'h5A), idle_c);
        chk("t1_a_ready", a_ready, 1'b1);
        step(idle_c, idle_c);
        chk("t1_rf", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd3, 8'h5A});
        step(idle_c, idle_c);
        chk("t1_rsp", {a_rsp_valid, a_rdata1}, {1'b1, 8'h13});
        step(idle_c, idle_c);
        chk("t1_rsp_once", a_rsp_valid, 1'b0);

        // B writes r5 then reads it back-to-back
        step(idle_c, mk(1'b0, 1'b1, 3'd0, 3'd1, 3'd5, 8'h77));
        chk("t3_b_ready0", b_ready, 1'b1);
        step(idle_c, mk(1'b0, 1'b0, 3'd5, 3'd2, 3'd0, 8'h00));
        chk("t3_b_ready1", b_ready, 1'b1);
        step(idle_c, idle_c);
        chk("t3_rsp0", {b_rsp_valid, b_rdata1}, {1'b1, 8'h10});
        step(idle_c, idle_c);
        chk("t3_rsp1", {b_rsp_valid, b_rdata1}, {1'b1, 8'h77});

        // both valid for 4 cycles: A, B, A, B
        ca_c = mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00);
        cb_c = mk(1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(ca_c, cb_c);
            chk("t2_grant", {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i == 3) chk("t2_b_rsp", {b_rsp_valid, b_rdata1}, {1'b1, 8'h5A});
        end
        step(idle_c, idle_c);
        step(idle_c, idle_c);

        // A locked sequence with an idle gap; B stalled until after unlock accept
        cb_c = mk(1'b0, 1'b0, 3'd6, 3'd7, 3'd0, 8'h00);
        step(mk(1'b1, 1'b0, 3'd1, 3'd1, 3'd0, 8'h00), cb_c);
        chk("t4_l1", {a_ready, b_ready}, 2'b10);
        step(idle_c, cb_c);
        chk("t4_idle_stall", b_ready, 1'b0);
        step(mk(1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 8'hC3), cb_c);
        chk("t4_l2", {a_ready, b_ready}, 2'b10);
        step(mk(1'b1, 1'b0, 3'd2, 3'd2, 3'd0, 8'h00), cb_c);
        chk("t4_l3", {a_ready, b_ready}, 2'b10);
        step(mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00), cb_c);
        chk("t4_unlock", {a_ready, b_ready}, 2'b10);
        step(idle_c, cb_c);
        chk("t4_b_after", b_ready, 1'b1);
        step(idle_c, idle_c);
        step(idle_c, idle_c);

        // lock timeout: A locks then goes idle, B waits
        step(mk(1'b1, 1'b0, 3'd4, 3'd5, 3'd0, 8'h00), idle_c);
        chk("t5_lock", a_ready, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) step(mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00), cb_c);
            else         step(idle_c, cb_c);
            chk("t5_timeout", lock_timeout, i == 16);
            chk("t5_b_ready", b_ready, i == 17);
        end
        chk("t5_tie_after", a_ready, 1'b0);
        step(idle_c, idle_c);
        step(idle_c, idle_c);

        // reset one cycle after a B accept drops the command
        step(idle_c, mk(1'b0, 1'b0, 3'd5, 3'd6, 3'd0, 8'h00));
        chk("t6_b_accept", b_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_in(idle_c, idle_c);
        @(negedge clk);
        chk("t6_rst_stage", {rf_raddr1, rf_raddr2, rf_we}, 7'd0);
        chk("t6_rst_rsp", b_rsp_valid, 1'b0);
        @(negedge clk);
        chk("t6_no_rsp", b_rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00), mk(1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 8'h00));
        @(negedge clk);
        chk("t6_first_tie", {a_ready, b_ready}, 2'b10);
        step(idle_c, idle_c);
        chk("t6_b_silent", b_rsp_valid, 1'b0);
        step(idle_c, idle_c);
        step(idle_c, idle_c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
